conf_mac_dot_seq: RTL and testbench
===================================

Name: conf_mac_dot_seq

Overview:
Sequencer that time-shares one external no-flop configurable-precision MAC to compute a dot product of length N over a streamed (a,b) operand sequence. It owns the accumulator register and chains each MAC output back as the next c operand. It selects accurate or approximate MAC mode per term under a job-level mode policy. A job is started by a start handshake and finishes with a result handshake. The block sits between an operand producer and the MAC datapath.

Parameters:
DATA_PATH_BITWIDTH, 32, width of operands, accumulator and MAC ports
Pn, 8, lowest requested precision; the approximate MAC zeroes the low 2*Pn result bits
LEN_W, 8, width of job length and term counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start_valid  in  1  job request
start_ready  out  1  high only in IDLE
cfg_len  in  LEN_W  number of terms N (0 allowed)
cfg_mode  in  2  00 accurate, 01 approx, 10 adaptive, 11 treated as accurate
cfg_init  in  DATA_PATH_BITWIDTH  initial accumulator value
op_valid  in  1  operand pair valid
op_ready  out  1  high only in RUN
op_a  in  DATA_PATH_BITWIDTH  operand a
op_b  in  DATA_PATH_BITWIDTH  operand b
abort  in  1  synchronous job cancel
mac_a  out  DATA_PATH_BITWIDTH  to MAC a (= op_a)
mac_b  out  DATA_PATH_BITWIDTH  to MAC b (= op_b)
mac_c  out  DATA_PATH_BITWIDTH  to MAC c (= acc register)
mac_apx__p  out  1  to MAC mode select
mac_d  in  DATA_PATH_BITWIDTH  MAC result, combinational from mac_a/b/c/apx__p
res_valid  out  1  result available
res_ready  in  1  result consumed
res_data  out  DATA_PATH_BITWIDTH  final accumulator
res_apx_cnt  out  LEN_W  number of terms computed in approximate mode

Behaviour:
- Reset (async, rst=1): state=IDLE; acc=0; term counter=0; apx counter=0; latched len/mode=0; res_valid=0; res_data=0; res_apx_cnt=0. start_ready=1 and op_ready=0 once reset is released.
- States: IDLE, RUN, DONE.
- IDLE: on start_valid&start_ready, latch cfg_len and cfg_mode, set acc=cfg_init, clear both counters.
  - cfg_len==0: go to DONE.
  - Otherwise go to RUN.
- RUN: op_ready=1. mac_a/mac_b/mac_c are driven combinationally every cycle.
  - mac_apx__p = 0 for accurate mode, 1 for approx mode.
  - Adaptive mode: mac_apx__p = 1 iff acc[DATA_PATH_BITWIDTH-1:2*Pn] != 0. The decision uses the registered acc, not mac_d.
  - On op_valid&op_ready: acc <= mac_d (truncated to DATA_PATH_BITWIDTH, wraps silently); term counter++; apx counter++ if mac_apx__p=1.
  - When the accepted term is number N (counter==len-1 at accept), go to DONE.
  - One term per cycle maximum; throughput 1 term/cycle; no pipeline latency beyond the acc register.
- DONE: res_valid=1, res_data=acc, res_apx_cnt=apx counter. These hold stable until res_ready. On res_valid&res_ready go to IDLE; res_valid drops the next cycle.
- Outside RUN: mac_apx__p=0, op_ready=0; mac_* still mirror op_a/op_b/acc (don't-care to MAC).
- abort=1 in RUN: go to IDLE next cycle, discard acc, no result.
  - An operand handshaking in the same cycle is consumed but not accumulated.
  - abort in IDLE or DONE is ignored.
- start_valid while not IDLE: ignored (start_ready=0), no queuing.
- rst asserted mid-job: immediate return to reset values; the partial job is lost.

Test Plan:
- Accurate, init=5, N=2, pairs (3,4),(10,20) -> res_data=217, res_apx_cnt=0, res_valid 2 cycles after start accept with op_valid held high.
- Approx, init=0, N=1, pair (0x305,0x400) -> res_data=0x000C0000, res_apx_cnt=1. Same job in accurate mode -> 0x000C1400.
- Adaptive, init=0x10000, N=2, pairs (0x305,0x400),(2,3) -> both terms apx, res_data=0x00D0000 then +(0)<<16 → 0x000D0000, res_apx_cnt=2. Adaptive with init=7, N=1, pair (2,3) -> accurate, res_data=13, res_apx_cnt=0.
- N=0, init=0x1234 -> DONE one cycle after start, res_data=0x1234, op_ready never asserted. Hold res_ready=0 for 5 cycles -> res_valid/res_data stable; start_valid ignored meanwhile.
- op_valid gaps and abort: N=4, deliver 2 terms with idle cycles between, assert abort -> IDLE, no res_valid. A following accurate job init=1, N=1, (2,2) -> res_data=5.
- Async rst pulsed mid-RUN between clock edges -> outputs return to reset values immediately; start_ready=1 after release.

Source files
------------

// File: rtl/conf_mac_dot_seq_if.sv
// rtl/conf_mac_dot_seq_if.sv - job, operand, MAC and result signal bundle for conf_mac_dot_seq
interface conf_mac_dot_seq_if #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int LEN_W = 8
);
    logic                          start_valid;
    logic                          start_ready;
    logic [LEN_W-1:0]              cfg_len;
    logic [1:0]                    cfg_mode;
    logic [DATA_PATH_BITWIDTH-1:0] cfg_init;
    logic                          op_valid;
    logic                          op_ready;
    logic [DATA_PATH_BITWIDTH-1:0] op_a;
    logic [DATA_PATH_BITWIDTH-1:0] op_b;
    logic                          abort;
    logic [DATA_PATH_BITWIDTH-1:0] mac_a;
    logic [DATA_PATH_BITWIDTH-1:0] mac_b;
    logic [DATA_PATH_BITWIDTH-1:0] mac_c;
    logic                          mac_apx__p;
    logic [DATA_PATH_BITWIDTH-1:0] mac_d;
    logic                          res_valid;
    logic                          res_ready;
    logic [DATA_PATH_BITWIDTH-1:0] res_data;
    logic [LEN_W-1:0]              res_apx_cnt;

    modport slave (
        input  start_valid, cfg_len, cfg_mode, cfg_init,
        input  op_valid, op_a, op_b, abort, mac_d, res_ready,
        output start_ready, op_ready, mac_a, mac_b, mac_c, mac_apx__p,
        output res_valid, res_data, res_apx_cnt
    );

    modport master (
        output start_valid, cfg_len, cfg_mode, cfg_init,
        output op_valid, op_a, op_b, abort, mac_d, res_ready,
        input  start_ready, op_ready, mac_a, mac_b, mac_c, mac_apx__p,
        input  res_valid, res_data, res_apx_cnt
    );
endinterface

// File: rtl/conf_mac_dot_seq.sv
// rtl/conf_mac_dot_seq.sv - dot-product sequencer time-sharing one external configurable-precision MAC
module conf_mac_dot_seq #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int Pn = 8,
    parameter int LEN_W = 8
) (
    input  logic clk,
    input  logic rst,
    conf_mac_dot_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_APX = 2'b01;
    localparam logic [1:0] MODE_ADP = 2'b10;

    state_t                        state;
    logic [DATA_PATH_BITWIDTH-1:0] acc;
    logic [LEN_W-1:0]              term_cnt;
    logic [LEN_W-1:0]              apx_cnt;
    logic [LEN_W-1:0]              len_q;
    logic [1:0]                    mode_q;
    logic                          res_valid_q;
    logic [DATA_PATH_BITWIDTH-1:0] res_data_q;
    logic [LEN_W-1:0]              res_apx_cnt_q;

    logic                          apx_sel;
    logic                          op_fire;
    logic [LEN_W-1:0]              last_idx;
    logic [LEN_W-1:0]              apx_cnt_nxt;

    // Adaptive mode drops to approximate once the registered sum has grown past the truncated bits.
    always_comb begin
        apx_sel = 1'b0;
        if (state == RUN) begin
            if (mode_q == MODE_APX)
                apx_sel = 1'b1;
            else if (mode_q == MODE_ADP)
                apx_sel = |acc[DATA_PATH_BITWIDTH-1:2*Pn];
        end
    end

    assign bus.mac_a       = bus.op_a;
    assign bus.mac_b       = bus.op_b;
    assign bus.mac_c       = acc;
    assign bus.mac_apx__p  = apx_sel;
    assign bus.start_ready = (state == IDLE);
    assign bus.op_ready    = (state == RUN);
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_apx_cnt = res_apx_cnt_q;

    assign op_fire     = bus.op_valid && (state == RUN);
    assign last_idx    = len_q - 1'b1;
    assign apx_cnt_nxt = apx_cnt + {{(LEN_W-1){1'b0}}, apx_sel};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            term_cnt      <= '0;
            apx_cnt       <= '0;
            len_q         <= '0;
            mode_q        <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_apx_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        len_q    <= bus.cfg_len;
                        mode_q   <= bus.cfg_mode;
                        acc      <= bus.cfg_init;
                        term_cnt <= '0;
                        apx_cnt  <= '0;
                        if (bus.cfg_len == '0) begin
                            state         <= DONE;
                            res_valid_q   <= 1'b1;
                            res_data_q    <= bus.cfg_init;
                            res_apx_cnt_q <= '0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over a coincident operand: it is handshaken but never summed.
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (op_fire) begin
                        acc      <= bus.mac_d;
                        term_cnt <= term_cnt + 1'b1;
                        apx_cnt  <= apx_cnt_nxt;
                        if (term_cnt == last_idx) begin
                            state         <= DONE;
                            res_valid_q   <= 1'b1;
                            res_data_q    <= bus.mac_d;
                            res_apx_cnt_q <= apx_cnt_nxt;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conf_mac_dot_seq.sv
// tb/tb_conf_mac_dot_seq.sv - self-checking bench for conf_mac_dot_seq against a dot-product reference model
module tb_conf_mac_dot_seq;
    localparam int W  = 32;
    localparam int PN = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    conf_mac_dot_seq_if #(.DATA_PATH_BITWIDTH(W), .LEN_W(LW)) bus ();

    conf_mac_dot_seq #(.DATA_PATH_BITWIDTH(W), .Pn(PN), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External MAC: d = a*b + c, approximate mode clears the low 2*Pn result bits.
    logic [W-1:0] mac_raw;
    assign mac_raw   = bus.mac_a * bus.mac_b + bus.mac_c;
    assign bus.mac_d = bus.mac_apx__p ? (mac_raw & ~((W'(1) << (2*PN)) - W'(1))) : mac_raw;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] va [16];
    logic [W-1:0] vb [16];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] init, input logic [1:0] mode, input int n,
                                  output logic [W-1:0] res, output logic [W-1:0] cnt);
        longint unsigned s;
        logic apx;
        res = init;
        cnt = '0;
        for (int i = 0; i < n; i++) begin
            apx = (mode == 2'b01) || (mode == 2'b10 && (res >> (2*PN)) != 0);
            s = (longint'(va[i]) * longint'(vb[i]) + longint'(res)) % (64'd1 << W);
            if (apx) s = (s >> (2*PN)) << (2*PN);
            res = W'(s);
            cnt = cnt + (apx ? 1 : 0);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [W-1:0] init, input logic [1:0] mode, input int n, output int t0);
        logic got, rdy;
        got = 1'b0;
        bus.start_valid = 1'b1;
        bus.cfg_init = init;
        bus.cfg_mode = mode;
        bus.cfg_len  = LW'(n);
        for (int i = 0; i < 20 && !got; i++) begin
            rdy = bus.start_ready;
            tick();
            if (rdy) got = 1'b1;
        end
        bus.start_valid = 1'b0;
        t0 = cyc;
        chk("start_accept", W'(got), W'(1));
    endtask

    task automatic feed(input int n, input int gap_pct);
        int idx;
        logic fire;
        idx = 0;
        for (int k = 0; k < 300 && idx < n; k++) begin
            bus.op_valid = ($urandom_range(99) >= gap_pct);
            bus.op_a = va[idx];
            bus.op_b = vb[idx];
            fire = bus.op_valid && bus.op_ready;
            tick();
            if (fire) idx++;
        end
        bus.op_valid = 1'b0;
        if (idx < n) chk("feed_timeout", W'(idx), W'(n));
    endtask

    task automatic finish_job(input string tag, input logic [W-1:0] init, input logic [1:0] mode,
                              input int n, input int t0, input int exp_lat, input int hold);
        logic [W-1:0] er, ec;
        model(init, mode, n, er, ec);
        for (int k = 0; k < 20 && !bus.res_valid; k++) tick();
        chk({tag, "_res_valid"}, W'(bus.res_valid), W'(1));
        if (exp_lat >= 0) chk({tag, "_latency"}, W'(cyc - t0), W'(exp_lat));
        chk({tag, "_res_data"}, bus.res_data, er);
        chk({tag, "_apx_cnt"}, W'(bus.res_apx_cnt), ec);
        for (int k = 0; k < hold; k++) tick();
        chk({tag, "_held_data"}, bus.res_data, er);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({tag, "_res_dropped"}, W'(bus.res_valid), W'(0));
        chk({tag, "_idle"}, W'(bus.start_ready), W'(1));
    endtask

    task automatic job(input string tag, input logic [W-1:0] init, input logic [1:0] mode,
                       input int n, input int gap_pct, input int exp_lat, input int hold);
        int t0;
        start_job(init, mode, n, t0);
        feed(n, gap_pct);
        finish_job(tag, init, mode, n, t0, exp_lat, hold);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(2))
            0:       return W'($urandom_range(255));
            1:       return W'($urandom_range(16'hFFFF));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int t0;
        logic [W-1:0] held;
        bus.start_valid = 0; bus.cfg_len = '0; bus.cfg_mode = '0; bus.cfg_init = '0;
        bus.op_valid = 0; bus.op_a = '0; bus.op_b = '0; bus.abort = 0; bus.res_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", W'(bus.res_valid), W'(0));
        chk("rst_res_data", bus.res_data, W'(0));
        chk("rst_apx_cnt", W'(bus.res_apx_cnt), W'(0));
        chk("rst_op_ready", W'(bus.op_ready), W'(0));
        chk("rst_mac_c", bus.mac_c, W'(0));
        rst = 1'b0;
        tick();
        chk("rst_start_ready", W'(bus.start_ready), W'(1));

        va[0] = 3; vb[0] = 4; va[1] = 10; vb[1] = 20;
        job("acc_n2", W'(5), 2'b00, 2, 0, 2, 0);
        chk("acc_n2_const", 32'd217, bus.mac_c);

        va[0] = 32'h305; vb[0] = 32'h400;
        start_job(W'(0), 2'b01, 1, t0);
        feed(1, 0);
        chk("apx_n1_data", bus.res_data, 32'h000C0000);
        chk("apx_n1_cnt", W'(bus.res_apx_cnt), W'(1));
        finish_job("apx_n1", W'(0), 2'b01, 1, t0, -1, 0);

        start_job(W'(0), 2'b00, 1, t0);
        feed(1, 0);
        chk("acc_n1_data", bus.res_data, 32'h000C1400);
        finish_job("acc_n1", W'(0), 2'b00, 1, t0, -1, 0);

        va[1] = 2; vb[1] = 3;
        start_job(32'h10000, 2'b10, 2, t0);
        feed(2, 0);
        chk("adp_big_data", bus.res_data, 32'h000D0000);
        chk("adp_big_cnt", W'(bus.res_apx_cnt), W'(2));
        finish_job("adp_big", 32'h10000, 2'b10, 2, t0, 2, 0);

        va[0] = 2; vb[0] = 3;
        start_job(W'(7), 2'b10, 1, t0);
        feed(1, 0);
        chk("adp_small_data", bus.res_data, W'(13));
        chk("adp_small_cnt", W'(bus.res_apx_cnt), W'(0));
        finish_job("adp_small", W'(7), 2'b10, 1, t0, 1, 0);

        // N=0: result appears straight from IDLE and must stay put while unconsumed.
        start_job(32'h1234, 2'b00, 0, t0);
        chk("n0_res_valid", W'(bus.res_valid), W'(1));
        chk("n0_res_data", bus.res_data, 32'h1234);
        held = bus.res_data;
        bus.start_valid = 1'b1; bus.cfg_len = 8'd3; bus.cfg_init = 32'hDEAD;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("n0_hold_valid", W'(bus.res_valid), W'(1));
            chk("n0_hold_data", bus.res_data, held);
            chk("n0_no_start", W'(bus.start_ready), W'(0));
            chk("n0_no_op", W'(bus.op_ready), W'(0));
        end
        bus.start_valid = 1'b0;
        finish_job("n0", 32'h1234, 2'b00, 0, t0, -1, 0);

        // Abort after two gapped terms, with an operand presented in the abort cycle.
        va[0] = 9; vb[0] = 9; va[1] = 7; vb[1] = 7; va[2] = 5; vb[2] = 5;
        start_job(W'(100), 2'b00, 4, t0);
        feed(2, 60);
        bus.abort = 1'b1; bus.op_valid = 1'b1; bus.op_a = 5; bus.op_b = 5;
        chk("abort_op_ready", W'(bus.op_ready), W'(1));
        tick();
        bus.abort = 1'b0; bus.op_valid = 1'b0;
        chk("abort_idle", W'(bus.start_ready), W'(1));
        chk("abort_no_res", W'(bus.res_valid), W'(0));
        tick();
        chk("abort_no_res2", W'(bus.res_valid), W'(0));
        va[0] = 2; vb[0] = 2;
        start_job(W'(1), 2'b00, 1, t0);
        feed(1, 0);
        chk("post_abort_data", bus.res_data, W'(5));
        finish_job("post_abort", W'(1), 2'b00, 1, t0, 1, 0);

        // Asynchronous reset between edges mid-RUN.
        va[0] = 11; vb[0] = 13;
        start_job(W'(50), 2'b00, 5, t0);
        feed(1, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_op_ready", W'(bus.op_ready), W'(0));
        chk("arst_mac_c", bus.mac_c, W'(0));
        chk("arst_res_valid", W'(bus.res_valid), W'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("arst_start_ready", W'(bus.start_ready), W'(1));

        for (int j = 0; j < 40; j++) begin
            int n;
            logic [1:0] mode;
            logic [W-1:0] init;
            n = $urandom_range(6);
            mode = 2'($urandom_range(3));
            init = ($urandom_range(1) == 0) ? W'($urandom_range(255)) : rnd_val();
            for (int i = 0; i < n; i++) begin
                va[i] = rnd_val();
                vb[i] = rnd_val();
            end
            job($sformatf("rnd%0d", j), init, mode, n, $urandom_range(40), -1, $urandom_range(2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
